// File: rtl/t05_pkg.sv
// Shared types and constants for the team 05 Huffman header path.
package t05_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT,
    ST_FLUSH,
    ST_DRAIN
  } hdr_ctrl_state_t;

  localparam int HDR_CHAR_BITS  = 9;
  localparam int HDR_MAX_ZEROES = 2;
  localparam int HDR_MAX_BITS   = HDR_CHAR_BITS + HDR_MAX_ZEROES;

  // Moves the low 'fill' bits of a partial byte to the top and zero-fills below.
  function automatic logic [7:0] left_align(input logic [7:0] partial, input logic [2:0] fill);
    return partial << (4'd8 - {1'b0, fill});
  endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// Small byte FIFO with free-entry count; a pop in the same cycle makes room for a push.
module t05_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (count == '0);
  assign full  = (count == DEPTH_V);
  assign free  = DEPTH_V - count;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/t05_header_controller.sv
// Sequences leaf events into header synthesis, packs the returned bit stream
// MSB-first into bytes and reports the header length once the tree is done.
module t05_header_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 node_valid,
  output logic                 node_ready,
  input  logic [7:0]           node_char,
  input  logic [8:0]           node_least1,
  input  logic [8:0]           node_least2,
  input  logic                 node_last,
  output logic [7:0]           hs_char_index,
  output logic                 hs_char_found,
  output logic [8:0]           hs_least1,
  output logic [8:0]           hs_least2,
  input  logic                 hs_enable,
  input  logic                 hs_bit1,
  input  logic                 hs_write_finish,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  input  logic                 byte_ready,
  output logic [BIT_CNT_W-1:0] header_bits,
  output logic                 done
);

  import t05_pkg::*;

  localparam int FREE_W   = $clog2(FIFO_DEPTH) + 1;
  // Bytes one worst-case header can complete; admitting a leaf needs this much room.
  localparam int MIN_FREE = (HDR_MAX_BITS + 7) / 8;

  hdr_ctrl_state_t   state;
  logic              last_q;
  logic              new_tree;
  logic              en_d;
  logic [7:0]        pack_sh;
  logic [2:0]        fill;
  logic              capture;
  logic              byte_done;
  logic              flush_push;
  logic              fifo_push;
  logic [7:0]        fifo_din;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FREE_W-1:0] fifo_free;

  assign node_ready = (state == ST_IDLE) && (fifo_free >= FREE_W'(MIN_FREE));
  assign capture    = en_d & ~hs_write_finish & ((state == ST_WAIT) | (state == ST_FLUSH));
  assign byte_done  = capture & (fill == 3'd7);
  assign flush_push = (state == ST_FLUSH) & ~capture & (fill != 3'd0) & ~fifo_full;
  assign fifo_push  = byte_done | flush_push;
  assign fifo_din   = byte_done ? {pack_sh[6:0], hs_bit1} : left_align(pack_sh, fill);
  assign byte_valid = ~fifo_empty;

  t05_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .nrst (nrst),
    .push (fifo_push),
    .din  (fifo_din),
    .pop  (byte_ready),
    .dout (byte_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .free (fifo_free)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      last_q        <= 1'b0;
      new_tree      <= 1'b1;
      en_d          <= 1'b0;
      pack_sh       <= '0;
      fill          <= '0;
      hs_char_index <= '0;
      hs_char_found <= 1'b0;
      hs_least1     <= '0;
      hs_least2     <= '0;
      header_bits   <= '0;
      done          <= 1'b0;
    end else begin
      en_d          <= hs_enable;
      hs_char_found <= 1'b0;
      done          <= 1'b0;

      // The fill count wraps to zero on the 8th bit, which is when byte_done pushes.
      if (capture) begin
        pack_sh <= {pack_sh[6:0], hs_bit1};
        fill    <= fill + 1'b1;
        if (header_bits != '1) header_bits <= header_bits + 1'b1;
      end else if (flush_push) begin
        fill <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (node_valid && node_ready) begin
            hs_char_index <= node_char;
            hs_least1     <= node_least1;
            hs_least2     <= node_least2;
            last_q        <= node_last;
            hs_char_found <= 1'b1;
            state         <= ST_FIRE;
            if (new_tree) begin
              header_bits <= '0;
              new_tree    <= 1'b0;
            end
          end
        end
        ST_FIRE: state <= ST_WAIT;
        ST_WAIT: begin
          if (hs_write_finish) state <= last_q ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: begin
          if (!capture && (fill == 3'd0 || !fifo_full)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            done     <= 1'b1;
            new_tree <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_header_controller.sv
// Bench for t05_header_controller: emulates header synthesis and checks packed bytes against a bit-string model.
module tb_t05_header_controller;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          node_valid = 1'b0;
  logic          node_ready;
  logic [7:0]    node_char = '0;
  logic [8:0]    node_least1 = '0;
  logic [8:0]    node_least2 = '0;
  logic          node_last = 1'b0;
  logic [7:0]    hs_char_index;
  logic          hs_char_found;
  logic [8:0]    hs_least1;
  logic [8:0]    hs_least2;
  logic          hs_enable = 1'b0;
  logic          hs_bit1 = 1'b0;
  logic          hs_write_finish = 1'b0;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready = 1'b0;
  logic [CW-1:0] header_bits;
  logic          done;

  t05_header_controller #(.FIFO_DEPTH(DEPTH), .BIT_CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst),
    .node_valid(node_valid), .node_ready(node_ready), .node_char(node_char),
    .node_least1(node_least1), .node_least2(node_least2), .node_last(node_last),
    .hs_char_index(hs_char_index), .hs_char_found(hs_char_found),
    .hs_least1(hs_least1), .hs_least2(hs_least2),
    .hs_enable(hs_enable), .hs_bit1(hs_bit1), .hs_write_finish(hs_write_finish),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .header_bits(header_bits), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic [8:0] l1;
    logic [8:0] l2;
    int         z;
    int         hcyc;
  } leaf_t;

  leaf_t      syn_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] pop_log[$];
  int         tree_bits[$];
  int         tree_total = 0;
  bit         tb_new_tree = 1'b1;
  bit         stall = 1'b0;
  int         total_cnt = 0;
  int         bad_cnt = 0;
  int         cyc = 0;
  int         done_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: the tree is one bit string, cut into bytes MSB-first, tail zero-padded.
  task automatic model_add_bit(input int b);
    logic [7:0] v;
    tree_bits.push_back(b);
    tree_total++;
    if (tree_bits.size() == 8) begin
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], 1'(tree_bits[i])};
      exp_bytes.push_back(v);
      tree_bits.delete();
    end
  endtask

  task automatic model_leaf(input logic [7:0] ch, input int z);
    model_add_bit(1);
    for (int i = 7; i >= 0; i--) model_add_bit(int'(ch[i]));
    for (int i = 0; i < z; i++) model_add_bit(0);
  endtask

  task automatic model_end_tree();
    logic [7:0] v;
    if (tree_bits.size() != 0) begin
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], (i < tree_bits.size()) ? 1'(tree_bits[i]) : 1'b0};
      exp_bytes.push_back(v);
      tree_bits.delete();
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < pop_log.size()) ? 32'(pop_log[i]) : 32'hDEAD;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Header synthesis stand-in: enable 2 cycles after char_found, 9+z bits, then finish.
  leaf_t cur;
  bit    syn_busy = 1'b0;
  int    syn_rel = 0;
  int    cur_bits[11];

  always begin
    @(posedge clk); #1;
    if (!nrst) begin
      syn_busy = 1'b0;
      hs_enable = 1'b0; hs_bit1 = 1'b0; hs_write_finish = 1'b0;
    end else if (syn_busy) begin
      syn_rel++;
      if (syn_rel == 1) checkOutput("char_found_pulse", 32'(hs_char_found), 0);
      hs_enable       = (syn_rel >= 2) && (syn_rel <= 10 + cur.z);
      hs_bit1         = (syn_rel >= 3 && syn_rel <= 11 + cur.z) ? 1'(cur_bits[syn_rel - 3]) : 1'b0;
      hs_write_finish = (syn_rel == 12 + cur.z);
      if (syn_rel == 12 + cur.z) begin
        checkOutput("least1_held", 32'(hs_least1), 32'(cur.l1));
        checkOutput("least2_held", 32'(hs_least2), 32'(cur.l2));
        syn_busy = 1'b0;
      end
    end else begin
      hs_enable = 1'b0; hs_bit1 = 1'b0; hs_write_finish = 1'b0;
      if (hs_char_found) begin
        if (syn_q.size() == 0) begin
          checkOutput("unexpected_char_found", 1, 0);
        end else begin
          cur = syn_q.pop_front();
          checkOutput("char_found_time", 32'(cyc), 32'(cur.hcyc + 1));
          checkOutput("char_index", 32'(hs_char_index), 32'(cur.ch));
          cur_bits[0] = 1;
          for (int i = 0; i < 8; i++) cur_bits[1 + i] = int'(cur.ch[7 - i]);
          for (int i = 9; i < 11; i++) cur_bits[i] = 0;
          syn_busy = 1'b1;
          syn_rel  = 0;
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    byte_ready = nrst && !stall && ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (nrst && byte_valid && byte_ready) begin
      pop_log.push_back(byte_data);
      if (exp_bytes.size() == 0) checkOutput("spurious_byte", 32'(byte_data), 32'hDEAD);
      else checkOutput("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
    end
    if (nrst && done) done_count++;
  end

  task automatic applyStimulus(input logic [7:0] ch, input logic [8:0] l1, input logic [8:0] l2,
                               input bit last, input int z);
    leaf_t e;
    int    waited = 0;
    bit    first;
    @(posedge clk); #1;
    node_valid = 1'b1; node_char = ch; node_least1 = l1; node_least2 = l2; node_last = last;
    @(negedge clk);
    while (!node_ready && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("leaf_accept", 32'(node_ready), 1);
    if (!node_ready) begin
      node_valid = 1'b0;
      return;
    end
    e.ch = ch; e.l1 = l1; e.l2 = l2; e.z = z; e.hcyc = cyc;
    syn_q.push_back(e);
    first = tb_new_tree;
    if (first) begin
      tree_total  = 0;
      tb_new_tree = 1'b0;
    end
    model_leaf(ch, z);
    if (last) begin
      model_end_tree();
      tb_new_tree = 1'b1;
    end
    @(posedge clk); #1;
    node_valid = 1'b0; node_last = 1'b0;
    if (first) begin
      @(negedge clk);
      checkOutput("header_bits_clear", 32'(header_bits), 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int start = done_count;
    int n = 0;
    while (done_count == start && n < 800) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_count != start), 1);
    checkOutput({tag, "_header_bits"}, 32'(header_bits), 32'(tree_total));
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_once"}, 32'(done_count - start), 1);
    checkOutput({tag, "_bytes_left"}, 32'(exp_bytes.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_char_found"}, 32'(hs_char_found), 0);
    checkOutput({tag, "_char_index"}, 32'(hs_char_index), 0);
    checkOutput({tag, "_least1"}, 32'(hs_least1), 0);
    checkOutput({tag, "_least2"}, 32'(hs_least2), 0);
    checkOutput({tag, "_byte_valid"}, 32'(byte_valid), 0);
    checkOutput({tag, "_byte_data"}, 32'(byte_data), 0);
    checkOutput({tag, "_header_bits"}, 32'(header_bits), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int n;
    #2 nrst = 1'b0;
    #1 check_reset_values("rst");
    repeat (3) @(posedge clk);
    #3 nrst = 1'b1;
    @(negedge clk);
    checkOutput("rst_node_ready", 32'(node_ready), 1);

    $display("[TB] single leaf 0x41, one zero");
    pop_log.delete();
    applyStimulus(8'h41, 9'h041, 9'h142, 1'b1, 1);
    wait_done("t1");
    checkOutput("t1_bits_const", 32'(header_bits), 10);
    checkOutput("t1_nbytes", 32'(pop_log.size()), 2);
    checkOutput("t1_byte0", log_at(0), 32'hA0);
    checkOutput("t1_byte1", log_at(1), 32'h80);

    $display("[TB] two leaves, padded tail");
    pop_log.delete();
    applyStimulus(8'h42, 9'h041, 9'h042, 1'b0, 2);
    applyStimulus(8'h43, 9'h043, 9'h144, 1'b1, 0);
    wait_done("t2");
    checkOutput("t2_bits_const", 32'(header_bits), 20);
    checkOutput("t2_nbytes", 32'(pop_log.size()), 3);
    checkOutput("t2_byte0", log_at(0), 32'hA1);
    checkOutput("t2_byte1", log_at(1), 32'h14);
    checkOutput("t2_byte2", log_at(2), 32'h30);

    $display("[TB] consumer stalled over a 4-leaf tree");
    pop_log.delete();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(8'h10 * (i + 1)), 9'(i), 9'(9'h100 + i), 1'b0, 2);
      repeat (19) @(negedge clk);
      checkOutput("stall_node_ready", 32'(node_ready), 32'((DEPTH - tree_total / 8) >= 2));
      checkOutput("stall_byte_valid", 32'(byte_valid), 1);
    end
    stall = 1'b0;
    applyStimulus(8'h40, 9'h003, 9'h103, 1'b1, 2);
    wait_done("t3");
    checkOutput("t3_nbytes", 32'(pop_log.size()), 6);

    $display("[TB] tree ending on a byte boundary");
    pop_log.delete();
    applyStimulus(8'hC3, 9'h0C3, 9'h1C3, 1'b0, 2);
    applyStimulus(8'h5A, 9'h05A, 9'h15A, 1'b0, 2);
    applyStimulus(8'hFF, 9'h0FF, 9'h1FF, 1'b1, 1);
    wait_done("t4");
    checkOutput("t4_nbytes", 32'(pop_log.size()), 4);

    $display("[TB] reset during WAIT");
    applyStimulus(8'h55, 9'h055, 9'h1AA, 1'b1, 1);
    repeat (5) @(posedge clk);
    #3 nrst = 1'b0;
    #1 check_reset_values("midrst");
    syn_q.delete(); exp_bytes.delete(); tree_bits.delete();
    tree_total = 0; tb_new_tree = 1'b1;
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    pop_log.delete();
    applyStimulus(8'h7E, 9'h07E, 9'h17E, 1'b1, 0);
    wait_done("t5");
    checkOutput("t5_byte0", log_at(0), 32'hBF);
    checkOutput("t5_byte1", log_at(1), 32'h00);

    $display("[TB] random trees");
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        applyStimulus(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
                      9'($urandom_range(0, 511)), i == n - 1, $urandom_range(0, 2));
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
